// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump_reader_pkg                                                  |
// | Register-file geometry and dump-reader FSM state encoding.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package regfile_dump_reader_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] C_ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] C_ST_READ  = 3'd1;
  localparam logic [ST_W-1:0] C_ST_EMIT0 = 3'd2;
  localparam logic [ST_W-1:0] C_ST_EMIT1 = 3'd3;
  localparam logic [ST_W-1:0] C_ST_DONE  = 3'd4;

  // One streamed (index, value) pair as seen by the debug consumer.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] index;
    logic [RF_DATA_W-1:0] data;
  } dump_beat_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump_reader_if                                                   |
// | Valid/ready beat stream carrying (index, value) pairs to the debug path. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_dump_reader                                                      |
// | Walks a register range two at a time over both RegFile read ports and    |
// | streams each (index, value) pair out; never writes the register file.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    ReadReg1,
  output logic [ADDR_W-1:0]    ReadReg2,
  input  logic [DATA_W-1:0]    ReadData1,
  input  logic [DATA_W-1:0]    ReadData2,
  regfile_dump_reader_if.master out_if,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] c_first = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_two   = ADDR_W'(2);

  logic [ST_W-1:0]   r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_buf1;
  logic [DATA_W-1:0] r_buf2;
  logic              r_busy;

  logic [ADDR_W-1:0] w_addr_p1;
  logic [ADDR_W-1:0] w_rr2;
  logic              w_handshake;

  // addr+1 is only consumed while addr < LAST_REG, so it can never wrap.
  assign w_addr_p1   = r_addr + c_one;
  assign w_rr2       = (r_addr < c_last) ? w_addr_p1 : c_last;
  assign w_handshake = out_if.out_valid && out_if.out_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= C_ST_IDLE;
      r_addr  <= c_first;
      r_buf1  <= '0;
      r_buf2  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (start) begin
            r_addr  <= c_first;
            r_busy  <= 1'b1;
            r_state <= C_ST_READ;
          end
        end
        C_ST_READ: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= C_ST_IDLE;
          end else begin
            r_buf1  <= ReadData1;
            r_buf2  <= ReadData2;
            r_state <= C_ST_EMIT0;
          end
        end
        C_ST_EMIT0: begin
          // abort wins over a same-cycle handshake: the beat is dropped.
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= C_ST_IDLE;
          end else if (w_handshake) begin
            r_state <= (r_addr == c_last) ? C_ST_DONE : C_ST_EMIT1;
          end
        end
        C_ST_EMIT1: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= C_ST_IDLE;
          end else if (w_handshake) begin
            if (w_addr_p1 == c_last) begin
              r_state <= C_ST_DONE;
            end else begin
              r_addr  <= r_addr + c_two;
              r_state <= C_ST_READ;
            end
          end
        end
        C_ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= C_ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode purely from registered state, so a stalled beat holds steady.
  always_comb begin
    ReadReg1         = '0;
    ReadReg2         = '0;
    out_if.out_valid = 1'b0;
    out_if.out_index = '0;
    out_if.out_data  = '0;
    case (r_state)
      C_ST_READ: begin
        ReadReg1 = r_addr;
        ReadReg2 = w_rr2;
      end
      C_ST_EMIT0: begin
        out_if.out_valid = 1'b1;
        out_if.out_index = r_addr;
        out_if.out_data  = r_buf1;
      end
      C_ST_EMIT1: begin
        out_if.out_valid = 1'b1;
        out_if.out_index = w_addr_p1;
        out_if.out_data  = r_buf2;
      end
      default: begin
      end
    endcase
  end

  assign busy = r_busy;
  assign done = (r_state == C_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_dump_reader                                                   |
// | Scoreboard bench: full-range and odd-range readers share one regfile.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic          start_a, abort_a, start_b, abort_b;
  logic [AW-1:0] rr1_a, rr2_a, rr1_b, rr2_b;
  logic          busy_a, done_a, busy_b, done_b;
  logic [DW-1:0] rf [32];

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .CLK(CLK), .RST(RST), .start(start_a), .abort(abort_a),
    .ReadReg1(rr1_a), .ReadReg2(rr2_a), .ReadData1(rf[rr1_a]), .ReadData2(rf[rr2_a]),
    .out_if(if_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(6), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .abort(abort_b),
    .ReadReg1(rr1_b), .ReadReg2(rr2_b), .ReadData1(rf[rr1_b]), .ReadData2(rf[rr2_b]),
    .out_if(if_b), .busy(busy_b), .done(done_b)
  );

  dump_beat_t  exp_a[$];
  dump_beat_t  exp_b[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          max_rr2_b = 0;
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_a(input int first, input int last);
    for (int i = first; i <= last; i++) exp_a.push_back('{index: AW'(i), data: 32'h100 + 32'(i)});
  endtask

  task automatic push_b(input int first, input int last);
    for (int i = first; i <= last; i++) exp_b.push_back('{index: AW'(i), data: 32'h100 + 32'(i)});
  endtask

  // Compares every presented beat against the scoreboard head; pops on transfer.
  task automatic monitor_loop();
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (int'(rr2_b) > max_rr2_b) max_rr2_b = int'(rr2_b);
        if (if_a.out_valid && !abort_a) begin
          if (exp_a.size() == 0) begin
            n_total++;
            $display("FAIL a_unexpected_beat: got index %0d, expected no beat", if_a.out_index);
          end else begin
            check("a_beat_index", 64'(if_a.out_index), 64'(exp_a[0].index));
            check("a_beat_data", 64'(if_a.out_data), 64'(exp_a[0].data));
            if (if_a.out_ready) void'(exp_a.pop_front());
          end
        end
        if (if_b.out_valid && !abort_b) begin
          if (exp_b.size() == 0) begin
            n_total++;
            $display("FAIL b_unexpected_beat: got index %0d, expected no beat", if_b.out_index);
          end else begin
            check("b_beat_index", 64'(if_b.out_index), 64'(exp_b[0].index));
            check("b_beat_data", 64'(if_b.out_data), 64'(exp_b[0].data));
            if (if_b.out_ready) void'(exp_b.pop_front());
          end
        end
      end
    end
  endtask

  task automatic pulse_start_a();
    @(posedge CLK); #1 start_a = 1'b1;
    @(posedge CLK); #1 start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge CLK); #1 start_b = 1'b1;
    @(posedge CLK); #1 start_b = 1'b0;
  endtask

  // Counts busy cycles until done; optionally drives pseudo-random backpressure.
  task automatic wait_done(input bit sel_b, input bit bp, input int limit,
                           output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      if (sel_b ? busy_b : busy_a) busy_cyc++;
      if (sel_b ? done_b : done_a) seen = 1'b1;
      if (bp && !seen) begin
        @(posedge CLK); #1;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if_a.out_ready = lfsr[0];
      end
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    int cnt_v, cnt_d, cnt_b;

    fork
      monitor_loop();
    join_none

    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    RST = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;

    @(negedge CLK);
    check("rst_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_readreg1", 64'(rr1_a), 64'd0);
    check("rst_readreg2", 64'(rr2_a), 64'd0);
    check("rst_index", 64'(if_a.out_index), 64'd0);
    check("rst_data", 64'(if_a.out_data), 64'd0);

    // Full dump, no backpressure.
    if_a.out_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    wait_done(1'b0, 1'b0, 200, cyc, seen);
    check("t1_done_seen", 64'(seen), 64'd1);
    check("t1_busy_cycles", 64'(cyc), 64'd49);
    @(negedge CLK);
    check("t1_busy_after", 64'(busy_a), 64'd0);
    check("t1_queue_drained", 64'(exp_a.size()), 64'd0);

    // Same dump under pseudo-random backpressure.
    push_a(0, 31);
    pulse_start_a();
    wait_done(1'b0, 1'b1, 600, cyc, seen);
    if_a.out_ready = 1'b1;
    check("t2_done_seen", 64'(seen), 64'd1);
    check("t2_busy_at_least_49", 64'(cyc >= 49), 64'd1);
    check("t2_queue_drained", 64'(exp_a.size()), 64'd0);

    // Odd range 2..6 on the second reader.
    push_b(2, 6);
    pulse_start_b();
    wait_done(1'b1, 1'b0, 100, cyc, seen);
    check("t3_done_seen", 64'(seen), 64'd1);
    check("t3_busy_cycles", 64'(cyc), 64'd9);
    check("t3_readreg2_max", 64'(max_rr2_b), 64'd6);
    check("t3_queue_drained", 64'(exp_b.size()), 64'd0);

    // Abort during EMIT1 of the second pair (index 3 never transfers).
    push_a(0, 2);
    pulse_start_a();
    repeat (5) @(posedge CLK);
    #1 abort_a = 1'b1;
    check("t4_abort_point_valid", 64'(if_a.out_valid), 64'd1);
    check("t4_abort_point_index", 64'(if_a.out_index), 64'd3);
    @(posedge CLK);
    #1 abort_a = 1'b0;
    check("t4_valid_after_abort", 64'(if_a.out_valid), 64'd0);
    check("t4_busy_after_abort", 64'(busy_a), 64'd0);
    cnt_d = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done_a) cnt_d++;
    end
    check("t4_no_done_pulse", 64'(cnt_d), 64'd0);
    check("t4_queue_drained", 64'(exp_a.size()), 64'd0);
    push_a(0, 31);
    pulse_start_a();
    wait_done(1'b0, 1'b0, 200, cyc, seen);
    check("t4_restart_done_seen", 64'(seen), 64'd1);
    check("t4_restart_busy_cycles", 64'(cyc), 64'd49);

    // Reset asserted while beat 0 is stalled in EMIT0.
    if_a.out_ready = 1'b0;
    push_a(0, 0);
    pulse_start_a();
    @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    check("t5_valid_in_reset", 64'(if_a.out_valid), 64'd0);
    check("t5_busy_in_reset", 64'(busy_a), 64'd0);
    check("t5_index_in_reset", 64'(if_a.out_index), 64'd0);
    exp_a.delete();
    @(negedge CLK) RST = 1'b1;
    if_a.out_ready = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (if_a.out_valid || busy_a) cnt_v++;
    end
    check("t5_idle_after_release", 64'(cnt_v), 64'd0);

    // Extra start pulses while busy (including in DONE) are ignored.
    push_a(0, 31);
    pulse_start_a();
    cnt_b = 0;
    cnt_d = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (busy_a) cnt_b++;
      if (done_a) cnt_d++;
      @(posedge CLK);
      #1 start_a = (i == 4 || i == 20 || i == 47);
    end
    start_a = 1'b0;
    check("t6_busy_cycles", 64'(cnt_b), 64'd49);
    check("t6_done_pulses", 64'(cnt_d), 64'd1);
    check("t6_busy_after", 64'(busy_a), 64'd0);
    check("t6_queue_drained", 64'(exp_a.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
